// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters; optional stats via BTB_STATS_EN.
// Latency: lookup is combinational (0 cycles); updates become visible the cycle after the write edge.
// Backpressure: none; ready stays low during the table init sweep, and updates are dropped while it is low.
module branch_target_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              ready,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
`ifdef BTB_STATS_EN
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_mispredicts,
`endif
  input  logic              clear
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   init_idx, init_idx_nxt;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  logic               upd_hit;
  logic               tbl_we;

  // Bits [1:0] of either PC never select anything (word-aligned instructions).
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // State register; rst restarts the init sweep from entry 0 even mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  // Next-state: sweep every entry in INIT, then RUN until a clear request.
  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    ready        = 1'b0;
    case (state)
      INIT: begin
        init_idx_nxt = init_idx + IDX_W'(1);
        if (init_idx == IDX_W'(ENTRIES - 1)) state_nxt = RUN;
      end
      RUN: begin
        ready = 1'b1;
        if (clear) begin
          state_nxt    = INIT;
          init_idx_nxt = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Combinational lookup against the pre-update table contents.
  always_comb begin
    pred_hit    = ready & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit & ctr_q[lk_idx][CTR_W-1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);
  end

  // A clear in the same cycle wins over the update; nothing is written outside RUN.
  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign tbl_we  = ready & upd_valid & ~clear & ~rst;

  // Valid bits: cleared one per cycle by the sweep, set on allocation.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      valid_q[init_idx] <= 1'b0;
    end else if (tbl_we && !upd_hit && upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Entry payload: train the counter on a hit, allocate weakly-taken on a taken miss.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == CTR_MAX) ? CTR_MAX : ctr_q[upd_idx] + CTR_W'(1);
          target_q[upd_idx] <= upd_target;
        end else begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == '0) ? '0 : ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WEAK;
      end
    end
  end

`ifdef BTB_STATS_EN
  // Free-running statistics; only rst zeroes them, clear leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_en && ready)                     stat_lookups     <= stat_lookups + STAT_W'(1);
      if (lookup_en && pred_hit)                  stat_hits        <= stat_hits + STAT_W'(1);
      if (upd_valid && upd_mispredict && ready)   stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`else
  // Without statistics these inputs only matter to the pipeline, not to the table.
  logic unused_stat_inputs;
  assign unused_stat_inputs = &{1'b0, lookup_en, upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized plus directed bench for branch_target_predictor against a table-level reference model.
// Latency: model predicts combinational outputs each cycle before the clock edge.
// Backpressure: not applicable; the bench drives one transaction per cycle.
module tb_branch_target_predictor;
  localparam int AW = 32;
  localparam int N  = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, lookup_en, upd_valid, upd_taken, upd_mispredict, clear;
  logic [AW-1:0] lookup_pc, upd_pc, upd_target;
  logic          pred_hit, pred_taken, ready;
  logic [AW-1:0] pred_target;
`ifdef BTB_STATS_EN
  logic [31:0]   stat_lookups, stat_hits, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_target_predictor #(.ADDR_W(AW), .ENTRIES(N), .CTR_W(CW), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target), .ready(ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict),
`ifdef BTB_STATS_EN
    .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts),
`endif
    .clear(clear)
  );

  // Reference model: one record per table slot, plus a countdown until predictions resume.
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];
  int          init_left;
  int unsigned ms_lk, ms_hit, ms_mis;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return (init_left == 0) && m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
  endfunction

  task automatic check_outputs();
    bit          h, t;
    logic [31:0] tg;
    h  = m_hit(lookup_pc);
    t  = h && (m_ctr[slot(lookup_pc)] >= 2);
    tg = t ? m_target[slot(lookup_pc)] : lookup_pc + 32'd4;
    chk("ready", {31'b0, ready}, {31'b0, init_left == 0});
    chk("hit", {31'b0, pred_hit}, {31'b0, h});
    chk("taken", {31'b0, pred_taken}, {31'b0, t});
    chk("target", pred_target, tg);
`ifdef BTB_STATS_EN
    chk("st_lk", stat_lookups, ms_lk);
    chk("st_hit", stat_hits, ms_hit);
    chk("st_mis", stat_mispredicts, ms_mis);
`endif
  endtask

  // Apply what the clock edge should do to the model, from the held inputs.
  task automatic model_edge();
    int s;
    bit rdy, h;
    rdy = (init_left == 0);
    h   = m_hit(lookup_pc);
    if (rst) begin
      ms_lk = 0; ms_hit = 0; ms_mis = 0;
    end else begin
      if (lookup_en && rdy) ms_lk++;
      if (lookup_en && h) ms_hit++;
      if (upd_valid && upd_mispredict && rdy) ms_mis++;
    end
    if (rst || (rdy && clear)) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      init_left = N;
    end else if (!rdy) begin
      init_left--;
    end else if (upd_valid) begin
      s = slot(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_target[s] = upd_target;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (upd_taken) begin
        m_valid[s]  = 1'b1;
        m_tag[s]    = tag_of(upd_pc);
        m_target[s] = upd_target;
        m_ctr[s]    = 2;
      end
    end
  endtask

  task automatic step(input bit do_chk);
    #1;
    if (do_chk) check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; lookup_en = 0; lookup_pc = '0; upd_valid = 0; upd_pc = '0;
    upd_taken = 0; upd_target = '0; upd_mispredict = 0; clear = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 7) == 0) pc = $urandom;
    else pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
    return pc;
  endfunction

  initial begin
    idle();
    init_left = N;
    ms_lk = 0; ms_hit = 0; ms_mis = 0;
    @(posedge clk); #1;

    // Init sweep: 16 cycles not ready, an update inside the sweep is dropped.
    rst = 1; step(0); rst = 0;
    lookup_en = 1; lookup_pc = 32'h40;
    #1; chk("init_tgt", pred_target, 32'h44);
    chk("init_hit", {31'b0, pred_hit}, 32'd0);
    for (int c = 0; c < N; c++) begin
      if (c == 3) upd(32'h40, 1, 32'h999); else upd_valid = 0;
      step(1);
    end
    upd_valid = 0;
    #1; chk("ready_17", {31'b0, ready}, 32'd1);
    chk("no_alloc_init", {31'b0, pred_hit}, 32'd0);

    // Allocate.
    upd(32'h40, 1, 32'h100); step(1); upd_valid = 0;
    #1; chk("alloc_hit", {31'b0, pred_hit}, 32'd1);
    chk("alloc_tgt", pred_target, 32'h100);

    // Saturation down then up.
    for (int k = 0; k < 3; k++) begin
      upd(32'h40, 0, 32'h0); step(1); upd_valid = 0;
      #1; chk("nt_taken", {31'b0, pred_taken}, 32'd0);
      chk("nt_tgt", pred_target, 32'h44);
    end
    for (int k = 0; k < 4; k++) begin upd(32'h40, 1, 32'h100); step(1); end
    upd_valid = 0;
    #1; chk("sat_taken", {31'b0, pred_taken}, 32'd1);

    // Alias on slot 0.
    lookup_pc = 32'h80; #1; chk("alias_miss", {31'b0, pred_hit}, 32'd0);
    upd(32'h80, 0, 32'h0); step(1); upd_valid = 0;
    lookup_pc = 32'h40; #1; chk("alias_keep", pred_target, 32'h100);
    upd(32'h80, 1, 32'h200); step(1); upd_valid = 0;
    #1; chk("alias_evict", {31'b0, pred_hit}, 32'd0);
    lookup_pc = 32'h80; #1; chk("alias_new", pred_target, 32'h200);

    // Same-cycle lookup and update.
    upd(32'h40, 1, 32'h150); step(1);
    lookup_pc = 32'h40; upd(32'h40, 1, 32'h300);
    #1; chk("simul_old", pred_target, 32'h150);
    step(1); upd_valid = 0;
    #1; chk("simul_new", pred_target, 32'h300);

    // Clear, then reset in the middle of the following sweep.
    clear = 1; upd(32'h44, 1, 32'h500); step(1); clear = 0; upd_valid = 0;
    for (int c = 0; c < N; c++) step(1);
    #1; chk("clr_ready", {31'b0, ready}, 32'd1);
    chk("clr_miss", {31'b0, pred_hit}, 32'd0);
    upd(32'h40, 1, 32'h600); step(1); upd_valid = 0;
    clear = 1; step(1); clear = 0;
    for (int c = 0; c < 5; c++) step(1);
    rst = 1; step(1); rst = 0;
    for (int c = 0; c < N - 1; c++) step(1);
    #1; chk("rst_mid_low", {31'b0, ready}, 32'd0);
    step(1);
    #1; chk("rst_mid_rdy", {31'b0, ready}, 32'd1);

    // Random traffic with aliasing-heavy PCs.
    for (int c = 0; c < 3000; c++) begin
      lookup_en      = ($urandom_range(0, 3) != 0);
      lookup_pc      = rand_pc();
      upd_valid      = $urandom_range(0, 1);
      upd_pc         = rand_pc();
      upd_taken      = ($urandom_range(0, 2) != 0);
      upd_target     = $urandom;
      upd_mispredict = $urandom_range(0, 1);
      clear          = ($urandom_range(0, 199) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      step(1);
    end
    idle();
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
